wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
Writeback stage that sits directly upstream of the register file write port (wr_addr0/wr_din0/we0). It accepts one retiring instruction per handshake from the memory stage. For loads, it waits for the data-memory response, then aligns and sign- or zero-extends the loaded data. It drives a single-cycle register write, a forwarding bus for the hazard logic, and an instret-style retire counter.

Parameters:
WIDTH, 32, data width; load formatting assumes 32.
DEPTH, 32, register count; address width AW = $clog2(DEPTH).
CNT_WIDTH, 32, width of the retire counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous active-high reset.
in_valid  input  1  MEM stage presents an instruction.
in_ready  output  1  stage can accept this cycle.
in_rd  input  AW  destination register.
in_wen  input  1  instruction writes rd.
in_is_load  input  1  result comes from data memory.
in_funct3  input  3  load type (RV32I encoding).
in_addr_lo  input  2  low two bits of the load address.
in_result  input  WIDTH  ALU/PC+4 result for non-loads.
dmem_rvalid  input  1  data-memory read response valid, one-cycle pulse.
dmem_rdata  input  WIDTH  raw aligned 32-bit memory word.
wr_addr0  output  AW  register file write address.
wr_din0  output  WIDTH  register file write data.
we0  output  1  register file write enable.
fwd_valid  output  1  fwd_rd/fwd_data hold a value being written this cycle.
fwd_rd  output  AW  forwarded register index.
fwd_data  output  WIDTH  forwarded value (equals wr_din0).
retire  output  1  one-cycle pulse per retired instruction.
retire_count  output  CNT_WIDTH  retired instruction count.
resp_err  output  1  sticky: unexpected dmem_rvalid seen.

Behaviour:
- State machine: IDLE, WAIT_LD, WB. All outputs are registered or decoded from state only; there is no combinational path from in_* to any output except in_ready, which depends on state only.
- in_ready = 1 in IDLE and WB, 0 in WAIT_LD. A handshake is in_valid & in_ready.
- Handshake with in_is_load = 0: latch rd, wen and result, then go to WB. Write occurs in the following cycle (latency 1).
- Handshake with in_is_load = 1: latch rd, wen, funct3 and addr_lo, then go to WAIT_LD. Remain there until dmem_rvalid. On dmem_rvalid, latch the formatted data and go to WB. Minimum load latency is 2 cycles from acceptance.
- A dmem_rvalid in the same cycle as the load's acceptance is not associated with that load. It is handled under the unexpected-response rule below.
- WB, with no handshake: go to IDLE.
- WB, with a handshake: go to WAIT_LD or WB per the rules above. This gives back-to-back non-loads at 1 per cycle.
- In WB:
  - we0 = latched wen & (rd != 0).
  - wr_addr0 = rd; wr_din0 = result.
  - fwd_valid = we0; fwd_rd = wr_addr0; fwd_data = wr_din0.
  - retire = 1, regardless of wen or rd.
- Outside WB: we0, fwd_valid and retire are 0. wr_addr0, wr_din0, fwd_rd and fwd_data are 0.
- The register file commits on the negative edge inside the WB cycle, so a same-cycle read after that edge sees the new value.
- Load formatting (byte lane b = addr_lo, half lane h = addr_lo[1]):
  - 000 LB: sign-extend byte b.
  - 001 LH: sign-extend half h; addr_lo[0] ignored.
  - 010 LW: full word.
  - 100 LBU: zero-extend byte b.
  - 101 LHU: zero-extend half h.
  - 011, 110, 111: treated as LW.
- retire_count increments by 1 in every WB cycle and wraps from all-ones to 0.
- resp_err is set when dmem_rvalid = 1 and state != WAIT_LD. It is cleared only by rst. The unexpected response is otherwise ignored.
- rst (synchronous):
  - State goes to IDLE.
  - All outputs are 0, except in_ready = 1 in the cycle after reset.
  - retire_count = 0 and resp_err = 0.
  - A load pending in WAIT_LD is dropped. Its late response, if it arrives, sets resp_err.
  - rst has priority over every other input in the same cycle.

Test Plan:
- Reset, then a non-load with rd=5, wen=1, result=0x1234_5678 accepted in cycle 0 -> cycle 1: we0=1, wr_addr0=5, wr_din0=0x12345678, retire=1, retire_count=1; cycle 2: we0=0.
- Load LB with addr_lo=3; dmem_rdata=0x80FF_7F01 arrives 3 cycles after accept -> in_ready=0 while waiting; one cycle after rvalid: wr_din0=0xFFFF_FF80.
- Repeat with LBU addr_lo=2 -> wr_din0=0x0000_00FF. Repeat with LH addr_lo=1 (h=0) -> wr_din0=0x0000_7F01. Repeat with LHU addr_lo=2 -> wr_din0=0x0000_80FF.
- Four back-to-back non-loads, with rd=0 on the second -> 4 consecutive WB cycles; we0 pattern 1,0,1,1; retire high all 4 cycles; retire_count=4.
- dmem_rvalid while IDLE -> resp_err=1 and stays 1. Accept a load, assert rst during WAIT_LD, then rvalid 2 cycles later -> no write; resp_err=1; retire_count=0.
- Preload retire_count to all-ones via a forced counter or 2^CNT_WIDTH retires (CNT_WIDTH=4 build acceptable), then one retire -> retire_count=0.

Source files
------------

// File: rtl/wb_stage.sv
// Writeback stage: retires one instruction per handshake, formats load data,
// and drives the register file write port, forwarding bus and retire counter.
module wb_stage #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 32,
  parameter int CNT_WIDTH = 32,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [AW-1:0]        in_rd,
  input  logic                 in_wen,
  input  logic                 in_is_load,
  input  logic [2:0]           in_funct3,
  input  logic [1:0]           in_addr_lo,
  input  logic [WIDTH-1:0]     in_result,
  input  logic                 dmem_rvalid,
  input  logic [WIDTH-1:0]     dmem_rdata,
  output logic [AW-1:0]        wr_addr0,
  output logic [WIDTH-1:0]     wr_din0,
  output logic                 we0,
  output logic                 fwd_valid,
  output logic [AW-1:0]        fwd_rd,
  output logic [WIDTH-1:0]     fwd_data,
  output logic                 retire,
  output logic [CNT_WIDTH-1:0] retire_count,
  output logic                 resp_err,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_LD = 2'd1,
    WB      = 2'd2
  } state_t;

  state_t        state_q;
  logic [AW-1:0] ld_rd;
  logic          ld_wen;
  logic [2:0]    ld_funct3;
  logic [1:0]    ld_addr_lo;

  // Handshake: a transfer happens on a rising edge where in_valid & in_ready;
  // in_ready depends on state only, so the MEM stage never sees a comb loop.
  assign in_ready  = (state_q != WAIT_LD);
  assign state     = state_q;
  assign fwd_valid = we0;
  assign fwd_rd    = wr_addr0;
  assign fwd_data  = wr_din0;

  function automatic logic [WIDTH-1:0] fmt_load(input logic [2:0] f3,
                                                input logic [1:0] lo,
                                                input logic [WIDTH-1:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lo, 3'b000});
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  fmt_load = {{(WIDTH-8){b[7]}}, b};
      3'b001:  fmt_load = {{(WIDTH-16){h[15]}}, h};
      3'b100:  fmt_load = {{(WIDTH-8){1'b0}}, b};
      3'b101:  fmt_load = {{(WIDTH-16){1'b0}}, h};
      default: fmt_load = word;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ld_rd        <= '0;
      ld_wen       <= 1'b0;
      ld_funct3    <= '0;
      ld_addr_lo   <= '0;
      we0          <= 1'b0;
      wr_addr0     <= '0;
      wr_din0      <= '0;
      retire       <= 1'b0;
      retire_count <= '0;
      resp_err     <= 1'b0;
    end else begin
      we0      <= 1'b0;
      wr_addr0 <= '0;
      wr_din0  <= '0;
      retire   <= 1'b0;
      // Any response outside WAIT_LD, including one in a load's accept cycle,
      // belongs to no outstanding load.
      if (dmem_rvalid && state_q != WAIT_LD)
        resp_err <= 1'b1;
      case (state_q)
        WAIT_LD: begin
          if (dmem_rvalid) begin
            state_q      <= WB;
            we0          <= ld_wen && (ld_rd != '0);
            wr_addr0     <= ld_rd;
            wr_din0      <= fmt_load(ld_funct3, ld_addr_lo, dmem_rdata);
            retire       <= 1'b1;
            retire_count <= retire_count + CNT_WIDTH'(1);
          end
        end
        default: begin
          if (in_valid) begin
            if (in_is_load) begin
              state_q    <= WAIT_LD;
              ld_rd      <= in_rd;
              ld_wen     <= in_wen;
              ld_funct3  <= in_funct3;
              ld_addr_lo <= in_addr_lo;
            end else begin
              state_q      <= WB;
              we0          <= in_wen && (in_rd != '0);
              wr_addr0     <= in_rd;
              wr_din0      <= in_result;
              retire       <= 1'b1;
              retire_count <= retire_count + CNT_WIDTH'(1);
            end
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage built with a 4-bit retire counter so the wrap
// case is reachable in a few cycles.
module tb_wb_stage;

  localparam int WIDTH = 32;
  localparam int AW    = 5;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [AW-1:0]    in_rd;
  logic             in_wen;
  logic             in_is_load;
  logic [2:0]       in_funct3;
  logic [1:0]       in_addr_lo;
  logic [WIDTH-1:0] in_result;
  logic             dmem_rvalid;
  logic [WIDTH-1:0] dmem_rdata;
  logic [AW-1:0]    wr_addr0;
  logic [WIDTH-1:0] wr_din0;
  logic             we0;
  logic             fwd_valid;
  logic [AW-1:0]    fwd_rd;
  logic [WIDTH-1:0] fwd_data;
  logic             retire;
  logic [CW-1:0]    retire_count;
  logic             resp_err;
  logic [1:0]       state;

  int checks = 0;
  int errors = 0;

  wb_stage #(.WIDTH(WIDTH), .DEPTH(32), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_wen(in_wen), .in_is_load(in_is_load),
    .in_funct3(in_funct3), .in_addr_lo(in_addr_lo), .in_result(in_result),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wr_addr0(wr_addr0), .wr_din0(wr_din0), .we0(we0),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .retire(retire), .retire_count(retire_count), .resp_err(resp_err),
    .state(state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid    = 1'b0;
    in_rd       = '0;
    in_wen      = 1'b0;
    in_is_load  = 1'b0;
    in_funct3   = '0;
    in_addr_lo  = '0;
    in_result   = '0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    checks++; if (we0 !== 1'b0) begin errors++; $display("FAIL reset_we0 got %0b want 0", we0); end
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL reset_retire got %0b want 0", retire); end
    checks++; if (retire_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", retire_count); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %0b want 0", resp_err); end
    checks++; if (wr_din0 !== 32'h0 || fwd_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_din0 got %h/%0b want 0/0", wr_din0, fwd_valid); end
  endtask

  task automatic test_nonload();
    in_valid = 1'b1; in_is_load = 1'b0; in_rd = 5'd5; in_wen = 1'b1; in_result = 32'h1234_5678;
    tick();
    idle_inputs();
    checks++; if (we0 !== 1'b1) begin errors++; $display("FAIL nl_we0 got %0b want 1", we0); end
    checks++; if (wr_addr0 !== 5'd5) begin errors++; $display("FAIL nl_addr got %0d want 5", wr_addr0); end
    checks++; if (wr_din0 !== 32'h1234_5678) begin errors++; $display("FAIL nl_din got %h want 12345678", wr_din0); end
    checks++; if (retire !== 1'b1) begin errors++; $display("FAIL nl_retire got %0b want 1", retire); end
    checks++; if (retire_count !== 4'd1) begin errors++; $display("FAIL nl_count got %0d want 1", retire_count); end
    checks++; if (fwd_valid !== 1'b1 || fwd_rd !== 5'd5 || fwd_data !== 32'h1234_5678) begin
      errors++; $display("FAIL nl_fwd got %0b/%0d/%h want 1/5/12345678", fwd_valid, fwd_rd, fwd_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL nl_ready_wb got %0b want 1", in_ready); end
    tick();
    checks++; if (we0 !== 1'b0 || retire !== 1'b0) begin errors++; $display("FAIL nl_after got we0=%0b retire=%0b want 0/0", we0, retire); end
  endtask

  // Load accepted, response 3 cycles after accept; count_want is the count after retiring
  task automatic test_load(input logic [2:0] f3, input logic [1:0] lo,
                           input logic [31:0] want, input logic [3:0] count_want);
    in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd7; in_wen = 1'b1;
    in_funct3 = f3; in_addr_lo = lo;
    tick();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      checks++; if (in_ready !== 1'b0 || we0 !== 1'b0) begin
        errors++; $display("FAIL ld_wait f3=%0d cyc=%0d got ready=%0b we0=%0b want 0/0", f3, i, in_ready, we0); end
      tick();
    end
    dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_7F01;
    tick();
    idle_inputs();
    checks++; if (wr_din0 !== want || we0 !== 1'b1 || wr_addr0 !== 5'd7) begin
      errors++; $display("FAIL ld_data f3=%0d lo=%0d got %h we0=%0b rd=%0d want %h 1 7", f3, lo, wr_din0, we0, wr_addr0, want); end
    checks++; if (retire !== 1'b1 || retire_count !== count_want) begin
      errors++; $display("FAIL ld_retire f3=%0d got %0b/%0d want 1/%0d", f3, retire, retire_count, count_want); end
    tick();
    checks++; if (we0 !== 1'b0 || resp_err !== 1'b0) begin
      errors++; $display("FAIL ld_after f3=%0d got we0=%0b err=%0b want 0/0", f3, we0, resp_err); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] rds [4];
    logic       we_want [4];
    rds = '{5'd1, 5'd0, 5'd2, 5'd3};
    we_want = '{1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_is_load = 1'b0; in_wen = 1'b1;
      in_rd = rds[i]; in_result = 32'hA000_0000 + 32'(i);
      tick();
      checks++; if (we0 !== we_want[i] || retire !== 1'b1 || wr_din0 !== 32'hA000_0000 + 32'(i)) begin
        errors++; $display("FAIL b2b_%0d got we0=%0b retire=%0b din=%h want %0b 1 %h", i, we0, retire, wr_din0, we_want[i], 32'hA000_0000 + 32'(i)); end
      checks++; if (retire_count !== 4'(i + 1)) begin
        errors++; $display("FAIL b2b_count_%0d got %0d want %0d", i, retire_count, i + 1); end
    end
    idle_inputs();
    tick();
    checks++; if (retire !== 1'b0 || retire_count !== 4'd4) begin
      errors++; $display("FAIL b2b_end got retire=%0b count=%0d want 0/4", retire, retire_count); end
  endtask

  task automatic test_resp_err();
    do_reset();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    checks++; if (resp_err !== 1'b1 || we0 !== 1'b0 || retire !== 1'b0) begin
      errors++; $display("FAIL err_idle got err=%0b we0=%0b retire=%0b want 1/0/0", resp_err, we0, retire); end
    tick();
    checks++; if (resp_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %0b want 1", resp_err); end
    do_reset();
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL err_clear got %0b want 0", resp_err); end
    // Load pending in WAIT_LD is dropped by reset; reset also beats a new offer
    in_valid = 1'b1; in_is_load = 1'b1; in_rd = 5'd9; in_wen = 1'b1; in_funct3 = 3'b010;
    tick();
    in_is_load = 1'b0; in_result = 32'h5555_5555;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    checks++; if (in_ready !== 1'b1 || retire !== 1'b0) begin
      errors++; $display("FAIL rst_drop got ready=%0b retire=%0b want 1/0", in_ready, retire); end
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
    tick();
    idle_inputs();
    checks++; if (we0 !== 1'b0 || retire !== 1'b0) begin
      errors++; $display("FAIL late_resp_write got we0=%0b retire=%0b want 0/0", we0, retire); end
    checks++; if (resp_err !== 1'b1 || retire_count !== 4'd0) begin
      errors++; $display("FAIL late_resp_err got err=%0b count=%0d want 1/0", resp_err, retire_count); end
  endtask

  task automatic test_wrap();
    do_reset();
    in_valid = 1'b1; in_is_load = 1'b0; in_rd = 5'd4; in_wen = 1'b0; in_result = 32'h0;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (retire_count !== 4'hF || we0 !== 1'b0) begin
      errors++; $display("FAIL wrap_pre got count=%0d we0=%0b want 15/0", retire_count, we0); end
    tick();
    idle_inputs();
    checks++; if (retire_count !== 4'h0 || retire !== 1'b1) begin
      errors++; $display("FAIL wrap got count=%0d retire=%0b want 0/1", retire_count, retire); end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_nonload();
    test_load(3'b000, 2'd3, 32'hFFFF_FF80, 4'd2);
    test_load(3'b100, 2'd2, 32'h0000_00FF, 4'd3);
    test_load(3'b001, 2'd1, 32'h0000_7F01, 4'd4);
    test_load(3'b101, 2'd2, 32'h0000_80FF, 4'd5);
    test_load(3'b010, 2'd1, 32'h80FF_7F01, 4'd6);
    test_load(3'b111, 2'd0, 32'h80FF_7F01, 4'd7);
    test_back_to_back();
    test_resp_err();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
